// File: rtl/sprite_mask_bank.sv
// Double-buffered per-object opacity masks: a serial pixel stream fills the back bank,
// a frame-swap pulse promotes completed masks, and a registered lookup reads the front bank.
module sprite_mask_bank #(
  parameter int NUM_OBJ  = 4,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int ID_W     = 3
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_load_start,
  input  logic [ID_W-1:0]                     i_load_obj,
  input  logic                                i_pix_valid,
  input  logic                                i_pix_opacity,
  output logic                                o_load_busy,
  output logic                                o_load_done,
  output logic                                o_load_err,
  input  logic                                i_frame_swap,
  input  logic                                i_q_valid,
  input  logic [ID_W-1:0]                     i_q_obj,
  input  logic signed [$clog2(SPRITE_W)+1:0]  i_q_x,
  input  logic signed [$clog2(SPRITE_H)+1:0]  i_q_y,
  output logic                                o_q_valid,
  output logic                                o_q_opaque
);

  localparam int XW    = $clog2(SPRITE_W) + 2;
  localparam int YW    = $clog2(SPRITE_H) + 2;
  localparam int NPIX  = SPRITE_W * SPRITE_H;
  localparam int PCW   = $clog2(NPIX);
  localparam int OBJ_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  localparam logic [PCW-1:0]       LAST_PIX = PCW'(NPIX - 1);
  localparam logic [ID_W:0]        OBJ_LIM  = (ID_W + 1)'(NUM_OBJ);
  localparam logic signed [XW-1:0] X_LIM    = XW'(SPRITE_W);
  localparam logic signed [YW-1:0] Y_LIM    = YW'(SPRITE_H);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state_reg;
  logic [OBJ_W-1:0]   obj_reg;
  logic [PCW-1:0]     pc_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;
  logic [NUM_OBJ-1:0] sel_reg;
  logic [NUM_OBJ-1:0] dirty_reg;
  logic               q_valid_reg;
  logic               q_opaque_reg;

  logic               load_obj_ok;
  logic               start_ok;
  logic               wr_en;
  logic               q_in_range;
  logic [PCW-1:0]     q_addr;
  logic [NUM_OBJ-1:0] front_bit;

  assign load_obj_ok = ({1'b0, i_load_obj} < OBJ_LIM);
  assign start_ok    = (state_reg == IDLE) && i_load_start && load_obj_ok;
  assign wr_en       = (state_reg == LOAD) && i_pix_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      obj_reg   <= '0;
      pc_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg  <= i_load_start && !start_ok;
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            state_reg <= LOAD;
            obj_reg   <= i_load_obj[OBJ_W-1:0];
            pc_reg    <= '0;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          if (i_pix_valid) begin
            pc_reg <= pc_reg + 1'b1;
            if (pc_reg == LAST_PIX) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Swap is evaluated before the DONE-cycle dirty set, so a swap landing on DONE misses it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sel_reg   <= '0;
      dirty_reg <= '0;
    end else begin
      for (int k = 0; k < NUM_OBJ; k++) begin
        if (i_frame_swap && dirty_reg[k]) begin
          sel_reg[k]   <= ~sel_reg[k];
          dirty_reg[k] <= 1'b0;
        end
      end
      if (start_ok)
        dirty_reg[i_load_obj[OBJ_W-1:0]] <= 1'b0;
      if (state_reg == DONE)
        dirty_reg[obj_reg] <= 1'b1;
    end
  end

  assign q_addr = PCW'(int'(i_q_y) * SPRITE_W + int'(i_q_x));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
      logic [NPIX-1:0] bank_reg [2];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          bank_reg[0] <= '0;
          bank_reg[1] <= '0;
        end else if (wr_en && (obj_reg == OBJ_W'(gi))) begin
          bank_reg[~sel_reg[gi]][pc_reg] <= i_pix_opacity;
        end
      end

      assign front_bit[gi] = bank_reg[sel_reg[gi]][q_addr];
    end
  endgenerate

  assign q_in_range = !i_q_x[XW-1] && (i_q_x < X_LIM) &&
                      !i_q_y[YW-1] && (i_q_y < Y_LIM) &&
                      ({1'b0, i_q_obj} < OBJ_LIM);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_valid_reg  <= 1'b0;
      q_opaque_reg <= 1'b0;
    end else begin
      q_valid_reg <= i_q_valid;
      if (i_q_valid)
        q_opaque_reg <= q_in_range && front_bit[i_q_obj[OBJ_W-1:0]];
    end
  end

  assign o_load_busy = busy_reg;
  assign o_load_done = done_reg;
  assign o_load_err  = err_reg;
  assign o_q_valid   = q_valid_reg;
  assign o_q_opaque  = q_opaque_reg;

endmodule

// File: tb/tb_sprite_mask_bank.sv
// Randomized bench for sprite_mask_bank against a front/pending mask model.
module tb_sprite_mask_bank;
  localparam int NOBJ = 4;
  localparam int NPIX = 256;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_load_start = 1'b0;
  logic [2:0]        i_load_obj = '0;
  logic              i_pix_valid = 1'b0;
  logic              i_pix_opacity = 1'b0;
  logic              o_load_busy;
  logic              o_load_done;
  logic              o_load_err;
  logic              i_frame_swap = 1'b0;
  logic              i_q_valid = 1'b0;
  logic [2:0]        i_q_obj = '0;
  logic signed [5:0] i_q_x = '0;
  logic signed [5:0] i_q_y = '0;
  logic              o_q_valid;
  logic              o_q_opaque;

  sprite_mask_bank dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_load_start(i_load_start), .i_load_obj(i_load_obj),
    .i_pix_valid(i_pix_valid), .i_pix_opacity(i_pix_opacity),
    .o_load_busy(o_load_busy), .o_load_done(o_load_done), .o_load_err(o_load_err),
    .i_frame_swap(i_frame_swap),
    .i_q_valid(i_q_valid), .i_q_obj(i_q_obj), .i_q_x(i_q_x), .i_q_y(i_q_y),
    .o_q_valid(o_q_valid), .o_q_opaque(o_q_opaque)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Model: what is displayed, what a finished load will commit, and the capture in flight.
  bit [NPIX-1:0] front   [NOBJ];
  bit [NPIX-1:0] pending [NOBJ];
  bit            pend_ok [NOBJ];
  bit [NPIX-1:0] cap;
  int            phase;   // 0 idle, 1 capturing, 2 finishing
  int            cur;
  int            cnt;
  bit exp_busy, exp_done, exp_err, exp_qv, exp_qo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit look(input int obj, input int x, input int y);
    if (obj >= NOBJ || x < 0 || x >= 16 || y < 0 || y >= 16) return 1'b0;
    return front[obj][y*16 + x];
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NOBJ; k++) begin
      front[k] = '0; pending[k] = '0; pend_ok[k] = 1'b0;
    end
    phase = 0; cnt = 0; cur = 0;
    exp_busy = 0; exp_done = 0; exp_err = 0; exp_qv = 0; exp_qo = 0;
  endfunction

  function automatic void model_edge();
    exp_qv = i_q_valid;
    if (i_q_valid) exp_qo = look(int'(i_q_obj), int'(i_q_x), int'(i_q_y));
    if (i_frame_swap)
      for (int k = 0; k < NOBJ; k++)
        if (pend_ok[k]) begin front[k] = pending[k]; pend_ok[k] = 1'b0; end
    exp_err = 0; exp_done = 0;
    case (phase)
      0: if (i_load_start) begin
           if (int'(i_load_obj) < NOBJ) begin
             phase = 1; cur = int'(i_load_obj); cnt = 0; pend_ok[cur] = 1'b0;
           end else exp_err = 1;
         end
      1: begin
           if (i_load_start) exp_err = 1;
           if (i_pix_valid) begin
             cap[cnt] = i_pix_opacity; cnt++;
             if (cnt == NPIX) begin phase = 2; exp_done = 1; end
           end
         end
      default: begin
           if (i_load_start) exp_err = 1;
           pending[cur] = cap; pend_ok[cur] = 1'b1; phase = 0;
         end
    endcase
    exp_busy = (phase == 1);
  endfunction

  task automatic tick();
    model_edge();
    @(posedge i_clk); #1;
    chk("busy", o_load_busy, exp_busy);
    chk("done", o_load_done, exp_done);
    chk("err", o_load_err, exp_err);
    chk("q_valid", o_q_valid, exp_qv);
    chk("q_opaque", o_q_opaque, exp_qo);
    i_load_start = 0; i_pix_valid = 0; i_frame_swap = 0; i_q_valid = 0;
  endtask

  task automatic rq();
    i_q_valid = 1'($urandom_range(0, 1));
    i_q_obj   = 3'($urandom_range(0, 4));
    i_q_x     = 6'($urandom_range(0, 21) - 3);
    i_q_y     = 6'($urandom_range(0, 21) - 3);
  endtask

  task automatic query(input int obj, input int x, input int y);
    i_q_valid = 1; i_q_obj = 3'(obj); i_q_x = 6'(x); i_q_y = 6'(y);
    tick();
  endtask

  task automatic do_reset();
    i_rst_n = 0; #2;
    chk("rst_busy", o_load_busy, 0);
    chk("rst_done", o_load_done, 0);
    chk("rst_err", o_load_err, 0);
    chk("rst_qv", o_q_valid, 0);
    chk("rst_qo", o_q_opaque, 0);
    model_reset();
    i_load_start = 0; i_pix_valid = 0; i_frame_swap = 0; i_q_valid = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
  endtask

  // mode 0: checkerboard (opaque where x+y odd); mode 1: random.
  task automatic do_load(input int obj, input int mode, input int swap_at, input int err_at,
                         input int stop_at);
    i_load_start = 1; i_load_obj = 3'(obj); rq(); tick();
    for (int idx = 0; idx < NPIX; idx++) begin
      if (idx == stop_at) return;
      while ($urandom_range(0, 3) == 0) begin rq(); tick(); end
      i_pix_valid = 1;
      i_pix_opacity = (mode == 0) ? 1'(((idx % 16) + (idx / 16)) & 1) : 1'($urandom_range(0, 1));
      if (idx == swap_at) i_frame_swap = 1;
      if (idx == err_at) begin i_load_start = 1; i_load_obj = 3'd2; end
      rq(); tick();
    end
    rq(); tick();
    $display("load obj=%0d mode=%0d finished checks=%0d", obj, mode, checks);
  endtask

  initial begin
    model_reset();
    do_reset();

    query(0, 3, 3);
    chk("reset_query", o_q_opaque, 0);

    do_load(1, 0, -1, -1, -1);
    query(1, 1, 0);
    chk("cb_preswap", o_q_opaque, 0);
    i_frame_swap = 1; tick();
    query(1, 1, 0);
    chk("cb_10", o_q_opaque, 1);
    query(1, 0, 0);
    chk("cb_00", o_q_opaque, 0);
    query(1, 3, 4);
    chk("cb_34", o_q_opaque, 1);

    query(1, -1, 5);  chk("oob_xneg", o_q_opaque, 0);
    query(1, 16, 0);  chk("oob_x16", o_q_opaque, 0);
    query(1, 0, 16);  chk("oob_y16", o_q_opaque, 0);
    query(4, 1, 0);   chk("oob_obj4", o_q_opaque, 0);

    // Swap after 100 pixels keeps the old checkerboard in front.
    do_load(1, 1, 100, -1, -1);
    query(1, 1, 0);
    chk("keep_old", o_q_opaque, 1);
    i_frame_swap = 1; tick();
    query(1, 1, 0);

    // Rejected start for obj 2 while obj 0 captures.
    do_load(0, 1, -1, 50, -1);
    i_frame_swap = 1; tick();
    for (int x = 0; x < 16; x++) begin query(2, x, x); chk("obj2_clean", o_q_opaque, 0); end

    // Swap coinciding with the final pixel does not commit.
    do_load(3, 0, 255, -1, -1);
    query(3, 1, 0);
    chk("final_swap_nocommit", o_q_opaque, 0);
    i_frame_swap = 1; tick();
    query(3, 1, 0);
    chk("next_swap_commit", o_q_opaque, 1);
    i_frame_swap = 1; tick();
    query(3, 1, 0);
    chk("sel_toggle_once", o_q_opaque, 1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        i_load_start = 1; i_load_obj = 3'($urandom_range(0, 5));
      end
      i_pix_valid = ($urandom_range(0, 9) < 7);
      i_pix_opacity = 1'($urandom_range(0, 1));
      i_frame_swap = ($urandom_range(0, 29) == 0);
      rq(); tick();
    end

    // Reset in the middle of a capture discards everything.
    do_load(2, 1, -1, -1, 60);
    do_reset();
    for (int n = 0; n < 30; n++) begin rq(); tick(); end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
